seq_restoring_divider: RTL and testbench

//  Multi-cycle unsigned integer divider; the inverse datapath of the

---
 rtl/seq_restoring_divider.sv | 101 ++++++++++
 tb/tb_seq_restoring_divider.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/ready/valid handshake.
// Divide-by-zero short-circuits to DONE with an all-ones quotient and the dividend as remainder.
module seq_restoring_divider #(
    parameter int unsigned dividend_width = 32,
    parameter int unsigned divisor_width  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [dividend_width-1:0] dividend,
    input  logic [divisor_width-1:0]  divisor,
    output logic                      ready,
    output logic                      valid,
    output logic [dividend_width-1:0] quotient,
    output logic [divisor_width-1:0]  remainder,
    output logic                      div_by_zero
);

    localparam int unsigned CntW = $clog2(dividend_width + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                    state_q;
    logic [dividend_width-1:0] d_q;
    logic [dividend_width-1:0] d_step;
    logic [divisor_width:0]    p_q;
    logic [divisor_width:0]    p_shift;
    logic [divisor_width:0]    p_step;
    logic [divisor_width-1:0]  dvs_q;
    logic [CntW-1:0]           cnt_q;
    logic                      q_bit;
    logic                      accept;

    assign accept = start && ready;

    // d_q doubles as the quotient accumulator: dividend bits leave at the top, quotient bits
    // enter at the bottom.
    always_comb begin
        p_shift = {p_q[divisor_width-1:0], d_q[dividend_width-1]};
        q_bit   = (p_shift >= {1'b0, dvs_q});
        p_step  = q_bit ? (p_shift - {1'b0, dvs_q}) : p_shift;
        d_step  = {d_q[dividend_width-2:0], q_bit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ready       <= 1'b1;
            valid       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            d_q         <= '0;
            p_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
        end else begin
            valid <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        if (divisor == '0) begin
                            state_q     <= StDone;
                            ready       <= 1'b1;
                            valid       <= 1'b1;
                            quotient    <= '1;
                            remainder   <= divisor_width'(dividend);
                            div_by_zero <= 1'b1;
                        end else begin
                            state_q     <= StBusy;
                            ready       <= 1'b0;
                            d_q         <= dividend;
                            dvs_q       <= divisor;
                            p_q         <= '0;
                            cnt_q       <= CntW'(dividend_width);
                            quotient    <= '0;
                            remainder   <= '0;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBusy: begin
                    p_q   <= p_step;
                    d_q   <= d_step;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q   <= StDone;
                        ready     <= 1'b1;
                        valid     <= 1'b1;
                        quotient  <= d_step;
                        remainder <= p_step[divisor_width-1:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of seq_restoring_divider at 8/8 bits and at the 32/32 defaults.
module tb_seq_restoring_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start32;
    logic [7:0]  dvd8, dvs8, quotient8, remainder8;
    logic [31:0] dvd32, dvs32, quotient32, remainder32;
    logic        ready8, valid8, dbz8, ready32, valid32, dbz32;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } vec_t;

    vec_t vecs[10];

    seq_restoring_divider #(.dividend_width(8), .divisor_width(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .ready       (ready8),
        .valid       (valid8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (dbz8)
    );

    seq_restoring_divider u_dut32 (
        .clk         (clk),
        .rst         (rst),
        .start       (start32),
        .dividend    (dvd32),
        .divisor     (dvs32),
        .ready       (ready32),
        .valid       (valid32),
        .quotient    (quotient32),
        .remainder   (remainder32),
        .div_by_zero (dbz32)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Accept one operation, then count negedges until valid (lat=1 means first cycle after accept).
    task automatic run_div(input bit wide, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dbz,
                           output int lat);
        @(negedge clk);
        if (wide) begin
            start32 = 1'b1; dvd32 = a; dvs32 = b;
        end else begin
            start8 = 1'b1; dvd8 = a[7:0]; dvs8 = b[7:0];
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        lat     = 1;
        while (!(wide ? valid32 : valid8) && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        q   = wide ? quotient32 : {24'b0, quotient8};
        r   = wide ? remainder32 : {24'b0, remainder8};
        dbz = wide ? dbz32 : dbz8;
    endtask

    initial begin
        logic [31:0] q, r, a, b, q1, r1;
        logic        dbz;
        int          lat, busy, pulses, t, t1;

        vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
        vecs[1] = '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1};
        vecs[2] = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
        vecs[3] = '{8'd3,   8'd200, 8'd0,   8'd3,   1'b0};
        vecs[4] = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
        vecs[5] = '{8'd200, 8'd9,   8'd22,  8'd2,   1'b0};
        vecs[6] = '{8'd50,  8'd5,   8'd10,  8'd0,   1'b0};
        vecs[7] = '{8'd0,   8'd3,   8'd0,   8'd0,   1'b0};
        vecs[8] = '{8'd254, 8'd16,  8'd15,  8'd14,  1'b0};
        vecs[9] = '{8'd0,   8'd0,   8'hFF,  8'd0,   1'b1};

        rst = 1'b1; start8 = 1'b0; start32 = 1'b0;
        dvd8 = '0; dvs8 = '0; dvd32 = '0; dvs32 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset ready",  ready8,     1'b1);
        check("reset valid",  valid8,     1'b0);
        check("reset q",      quotient8,  8'd0);
        check("reset r",      remainder8, 8'd0);
        check("reset dbz",    dbz8,       1'b0);

        foreach (vecs[i]) begin
            run_div(1'b0, {24'b0, vecs[i].a}, {24'b0, vecs[i].b}, q, r, dbz, lat);
            check($sformatf("vec%0d q", i),   q,   {24'b0, vecs[i].q});
            check($sformatf("vec%0d r", i),   r,   {24'b0, vecs[i].r});
            check($sformatf("vec%0d dbz", i), dbz, vecs[i].dbz);
            check($sformatf("vec%0d latency", i), lat, vecs[i].dbz ? 1 : 9);
        end

        // 100/7: busy for 8 cycles, valid on the 9th, then results held; operand changes ignored
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd1;
        busy = 0;
        for (int i = 0; i < 8; i++) begin
            if (!ready8 && !valid8) busy++;
            @(negedge clk);
        end
        check("t1 busy cycles", busy, 8);
        check("t1 valid", valid8, 1'b1);
        check("t1 ready", ready8, 1'b1);
        check("t1 q", quotient8, 8'd14);
        check("t1 r", remainder8, 8'd2);
        @(negedge clk);
        check("t1 valid drop", valid8, 1'b0);
        check("t1 q held", quotient8, 8'd14);
        check("t1 r held", remainder8, 8'd2);

        // divide by zero, then a normal accept clears dbz and results
        run_div(1'b0, 32'd5, 32'd0, q, r, dbz, lat);
        check("t2 dbz", dbz, 1'b1);
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        check("t2 dbz cleared", dbz8, 1'b0);
        check("t2 q cleared", quotient8, 8'd0);
        t = 0;
        while (!valid8 && t < 60) begin @(negedge clk); t++; end
        check("t2 follow-on q", quotient8, 8'd14);

        // start pulsed during BUSY is ignored
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; q1 = '0; r1 = '0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin start8 = 1'b1; dvd8 = 8'd9; dvs8 = 8'd3; end
            if (i == 4) start8 = 1'b0;
            if (valid8) begin pulses++; q1 = {24'b0, quotient8}; r1 = {24'b0, remainder8}; end
            @(negedge clk);
        end
        check("t4 pulses", pulses, 1);
        check("t4 q", q1, 32'd14);
        check("t4 r", r1, 32'd2);

        // reset mid-BUSY abandons the division
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd100; dvs8 = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5 ready", ready8, 1'b1);
        check("t5 valid", valid8, 1'b0);
        check("t5 q", quotient8, 8'd0);
        check("t5 r", remainder8, 8'd0);
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (valid8) pulses++;
            @(negedge clk);
        end
        check("t5 no pulse", pulses, 0);

        // start held across DONE: back-to-back accepts 9 cycles apart
        @(negedge clk);
        start8 = 1'b1; dvd8 = 8'd200; dvs8 = 8'd9;
        @(negedge clk);
        dvd8 = 8'd50; dvs8 = 8'd5;
        t = 1;
        while (!valid8 && t < 60) begin @(negedge clk); t++; end
        t1 = t; q1 = {24'b0, quotient8}; r1 = {24'b0, remainder8};
        @(negedge clk);
        start8 = 1'b0;
        t++;
        check("t6 second accepted", ready8, 1'b0);
        while (!valid8 && t < 80) begin @(negedge clk); t++; end
        check("t6 first latency", t1, 9);
        check("t6 pulse spacing", t - t1, 9);
        check("t6 q1", q1, 32'd22);
        check("t6 r1", r1, 32'd2);
        check("t6 q2", quotient8, 8'd10);
        check("t6 r2", remainder8, 8'd0);

        for (int i = 0; i < 200; i++) begin
            a = {24'b0, 8'($urandom_range(0, 255))};
            b = {24'b0, 8'($urandom_range(1, 255))};
            run_div(1'b0, a, b, q, r, dbz, lat);
            check($sformatf("rand8 %0d/%0d q", a, b), q, a / b);
            check($sformatf("rand8 %0d/%0d r", a, b), r, a % b);
        end

        run_div(1'b1, 32'd7, 32'd0, q, r, dbz, lat);
        check("w32 dbz q", q, 32'hFFFF_FFFF);
        check("w32 dbz r", r, 32'd7);
        check("w32 dbz flag", dbz, 1'b1);
        run_div(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, q, r, dbz, lat);
        check("w32 max q", q, 32'd1);
        check("w32 max r", r, 32'd0);
        check("w32 latency", lat, 33);
        run_div(1'b1, 32'd1000000007, 32'd12345, q, r, dbz, lat);
        check("w32 big q", q, 32'd81004);
        check("w32 big r", r, 32'd5627);
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = (i < 20) ? ($urandom | 32'd1) : 32'($urandom_range(1, 1000));
            run_div(1'b1, a, b, q, r, dbz, lat);
            check($sformatf("rand32 %0d/%0d q", a, b), q, a / b);
            check($sformatf("rand32 %0d/%0d r", a, b), r, a % b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
